// File: rtl/main_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_pkg
//  Description : Shared types and encodings for the multicycle main control
//                FSM: state enum, datapath mux-select encodings, instruction
//                op encodings and the packed control-word struct.
//  Revision    : 1.0  initial release
// ============================================================================
package main_fsm_pkg;

  // Minimum width needed to hold all state encodings.
  localparam int STATE_ENC_W = 4;

  typedef enum logic [STATE_ENC_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMRD    = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWR    = 4'd5,
    ST_EXECUTER = 4'd6,
    ST_EXECUTEI = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_UNKNOWN  = 4'd10
  } state_e;

  // ALU A operand select
  localparam logic [1:0] ALUSRCA_REG    = 2'b00;
  localparam logic [1:0] ALUSRCA_PC     = 2'b01;
  localparam logic [1:0] ALUSRCA_ALUOUT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b10;

  // Result bus select
  localparam logic [1:0] RESSRC_ALUOUT  = 2'b00;
  localparam logic [1:0] RESSRC_DATA    = 2'b01;
  localparam logic [1:0] RESSRC_ALURES  = 2'b10;

  // Instruction op field Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       instrdone;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/main_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_if
//  Description : Controller-to-datapath bundle for the main FSM.
//                master : the FSM (consumes Op/Funct, drives controls)
//                slave  : the decode/condition side (drives Op/Funct,
//                         consumes controls)
//  Signals     : Op[1:0], Funct[5:0] in; IRWrite, AdrSrc, ALUSrcA[1:0],
//                ALUSrcB[1:0], ResultSrc[1:0], ALUOp, NextPC, RegW, MemW,
//                Branch, InstrDone, Illegal out.
//  Revision    : 1.0  initial release
// ============================================================================
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, InstrDone, Illegal
  );

  modport slave (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
           NextPC, RegW, MemW, Branch, InstrDone, Illegal
  );
endinterface
`default_nettype wire

// File: rtl/flopr.sv
`default_nettype none
// ============================================================================
//  Module      : flopr
//  Description : Resettable register, asynchronous active-low clear to 0.
//  Ports       : clk, reset (active-low), d[WIDTH-1:0] in; q[WIDTH-1:0] out.
//  Revision    : 1.0  initial release
// ============================================================================
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/main_fsm_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_outdec
//  Description : Pure combinational state-to-control decode (Moore outputs).
//                Any encoding not in the state list decodes to all zeros.
//  Ports       : i_state (state_e) in; o_ctrl (ctrl_t) out.
//  Revision    : 1.0  initial release
// ============================================================================
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.irwrite   = 1'b1;
        o_ctrl.nextpc    = 1'b1;
        o_ctrl.alusrca   = ALUSRCA_PC;
        o_ctrl.alusrcb   = ALUSRCB_FOUR;
        o_ctrl.resultsrc = RESSRC_ALURES;
      end
      ST_DECODE: begin
        o_ctrl.alusrca   = ALUSRCA_PC;
        o_ctrl.alusrcb   = ALUSRCB_FOUR;
        o_ctrl.resultsrc = RESSRC_ALURES;
      end
      ST_MEMADR: begin
        o_ctrl.alusrca   = ALUSRCA_REG;
        o_ctrl.alusrcb   = ALUSRCB_IMM;
      end
      ST_MEMRD: begin
        o_ctrl.adrsrc    = 1'b1;
        o_ctrl.resultsrc = RESSRC_ALUOUT;
      end
      ST_MEMWB: begin
        o_ctrl.resultsrc = RESSRC_DATA;
        o_ctrl.regw      = 1'b1;
        o_ctrl.instrdone = 1'b1;
      end
      ST_MEMWR: begin
        o_ctrl.adrsrc    = 1'b1;
        o_ctrl.memw      = 1'b1;
        o_ctrl.instrdone = 1'b1;
      end
      ST_EXECUTER: begin
        o_ctrl.alusrca   = ALUSRCA_REG;
        o_ctrl.alusrcb   = ALUSRCB_REG;
        o_ctrl.aluop     = 1'b1;
      end
      ST_EXECUTEI: begin
        o_ctrl.alusrca   = ALUSRCA_REG;
        o_ctrl.alusrcb   = ALUSRCB_IMM;
        o_ctrl.aluop     = 1'b1;
      end
      ST_ALUWB: begin
        o_ctrl.resultsrc = RESSRC_ALUOUT;
        o_ctrl.regw      = 1'b1;
        o_ctrl.instrdone = 1'b1;
      end
      ST_BRANCH: begin
        o_ctrl.alusrca   = ALUSRCA_ALUOUT;
        o_ctrl.alusrcb   = ALUSRCB_IMM;
        o_ctrl.resultsrc = RESSRC_ALURES;
        o_ctrl.branch    = 1'b1;
        o_ctrl.instrdone = 1'b1;
      end
      ST_UNKNOWN: begin
        o_ctrl.instrdone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm
//  Description : Multicycle main control FSM. Steps each instruction through
//                fetch/decode/execute/memory/writeback and drives the
//                unconditioned strobes (NextPC, RegW, MemW, Branch) plus the
//                datapath mux selects. Moore machine: outputs depend on the
//                state register only (strobes are additionally held low while
//                reset is asserted).
//  Ports       : clk, reset (async, active-low), bus (main_fsm_if.master).
//  Parameters  : STATE_W - state register width, must be >= 4.
//  Config      : MAIN_FSM_ILLEGAL_TRAP_EN - when defined, UNKNOWN is a sink
//                state with Illegal=1 and a single InstrDone pulse on entry;
//                when undefined, UNKNOWN lasts one cycle and Illegal=0.
//  Revision    : 1.0  initial release
// ============================================================================
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  main_fsm_if.master   bus
);
  import main_fsm_pkg::*;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_d;
  logic [3:0]         w_state_low;
  state_e             w_state;
  state_e             w_next;
  ctrl_t              w_ctrl;
  logic               w_done_ok;
  logic [3:0]         w_unused_funct;

  assign w_unused_funct = bus.Funct[4:1];

  flopr #(.WIDTH(STATE_W)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (w_state_d),
    .q     (r_state)
  );

  // Any set bit above the enum width is a corrupt encoding; map it onto an
  // unused code so it decodes to idle outputs and recovers to FETCH.
  generate
    if (STATE_W > STATE_ENC_W) begin : g_wide_state
      assign w_state_low = (|r_state[STATE_W-1:STATE_ENC_W]) ? 4'hF
                                                             : r_state[3:0];
    end else begin : g_exact_state
      assign w_state_low = r_state[3:0];
    end
  endgenerate

  assign w_state   = state_e'(w_state_low);
  assign w_state_d = STATE_W'(w_next);

  always_comb begin
    w_next = ST_FETCH;
    case (w_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        case (bus.Op)
          OP_MEM:  w_next = ST_MEMADR;
          OP_DP:   w_next = bus.Funct[5] ? ST_EXECUTEI : ST_EXECUTER;
          OP_BR:   w_next = ST_BRANCH;
          default: w_next = ST_UNKNOWN;
        endcase
      end
      ST_MEMADR:   w_next = bus.Funct[0] ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:    w_next = ST_MEMWB;
      ST_MEMWB:    w_next = ST_FETCH;
      ST_MEMWR:    w_next = ST_FETCH;
      ST_EXECUTER: w_next = ST_ALUWB;
      ST_EXECUTEI: w_next = ST_ALUWB;
      ST_ALUWB:    w_next = ST_FETCH;
      ST_BRANCH:   w_next = ST_FETCH;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      ST_UNKNOWN:  w_next = ST_UNKNOWN;
`else
      ST_UNKNOWN:  w_next = ST_FETCH;
`endif
      default:     w_next = ST_FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .i_state (w_state),
    .o_ctrl  (w_ctrl)
  );

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  // Remembers that the previous cycle was already UNKNOWN, so InstrDone
  // fires only on the entry cycle of the trap.
  logic r_unk_seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_unk_seen <= 1'b0;
    else        r_unk_seen <= (w_state == ST_UNKNOWN);
  end

  assign w_done_ok   = !((w_state == ST_UNKNOWN) && r_unk_seen);
  assign bus.Illegal = (w_state == ST_UNKNOWN);
`else
  assign w_done_ok   = 1'b1;
  assign bus.Illegal = 1'b0;
`endif

  // Mux selects come straight from the state (FETCH values during reset);
  // strobes are masked by reset so an aborted instruction drops them at once.
  assign bus.AdrSrc    = w_ctrl.adrsrc;
  assign bus.ALUSrcA   = w_ctrl.alusrca;
  assign bus.ALUSrcB   = w_ctrl.alusrcb;
  assign bus.ResultSrc = w_ctrl.resultsrc;
  assign bus.ALUOp     = w_ctrl.aluop;
  assign bus.IRWrite   = w_ctrl.irwrite   & reset;
  assign bus.NextPC    = w_ctrl.nextpc    & reset;
  assign bus.RegW      = w_ctrl.regw      & reset;
  assign bus.MemW      = w_ctrl.memw      & reset;
  assign bus.Branch    = w_ctrl.branch    & reset;
  assign bus.InstrDone = w_ctrl.instrdone & reset & w_done_ok;

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_fsm
//  Description : Directed self-checking bench for main_fsm. Each task drives
//                one instruction class and compares the full output vector
//                per cycle against hand-written expected vectors.
//                Vector order: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
//                ALUOp, NextPC, RegW, MemW, Branch, InstrDone, Illegal}.
//  Config      : MAIN_FSM_ILLEGAL_TRAP_EN selects trap-mode expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_main_fsm;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  main_fsm_if bus ();

  main_fsm #(.STATE_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  localparam logic [14:0] E_FETCH  = {1'b1,1'b0,2'b01,2'b10,2'b10,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_RESET  = {1'b0,1'b0,2'b01,2'b10,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_DECODE = {1'b0,1'b0,2'b01,2'b10,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_MEMADR = {1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_MEMRD  = {1'b0,1'b1,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_MEMWB  = {1'b0,1'b0,2'b00,2'b00,2'b01,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
  localparam logic [14:0] E_MEMWR  = {1'b0,1'b1,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
  localparam logic [14:0] E_EXER   = {1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_EXEI   = {1'b0,1'b0,2'b00,2'b01,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] E_ALUWB  = {1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
  localparam logic [14:0] E_BRANCH = {1'b0,1'b0,2'b10,2'b01,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
  localparam logic [14:0] E_UNK    = {1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
  localparam logic [14:0] E_UNKH   = {1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
`else
  localparam logic [14:0] E_UNK    = {1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
`endif

  function automatic logic [14:0] obs();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.Branch,
            bus.InstrDone, bus.Illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] o;
    #1;
    for (int i = 0; i < 3; i++) begin
      o = obs();
      n_checks++;
      if (o !== E_RESET) $display("FAIL reset_hold[%0d] got=%h exp=%h", i, o, E_RESET);
      else n_pass++;
      step();
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    o = obs();
    n_checks++;
    if (o !== E_FETCH) $display("FAIL reset_release got=%h exp=%h", o, E_FETCH);
    else n_pass++;
  endtask

  // Entered in FETCH; leaves in FETCH of the next instruction.
  task automatic test_ldr();
    logic [14:0] exp_v [5];
    logic [14:0] o;
    exp_v = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    bus.Op = 2'b01; bus.Funct = 6'b011001;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      // Inputs are ignored after MEMADR has been left.
      if (i == 3) begin bus.Op = 2'b10; bus.Funct = 6'b000000; end
      o = obs();
      n_checks++;
      if (o !== exp_v[i]) $display("FAIL ldr_c%0d got=%h exp=%h", i + 1, o, exp_v[i]);
      else n_pass++;
    end
    step();
    o = obs();
    n_checks++;
    if (o !== E_FETCH) $display("FAIL ldr_return got=%h exp=%h", o, E_FETCH);
    else n_pass++;
  endtask

  task automatic test_str();
    logic [14:0] exp_v [5];
    logic [14:0] o;
    exp_v = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_FETCH};
    bus.Op = 2'b01; bus.Funct = 6'b011000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      o = obs();
      n_checks++;
      if (o !== exp_v[i]) $display("FAIL str_c%0d got=%h exp=%h", i + 1, o, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_add_reg();
    logic [14:0] exp_v [5];
    logic [14:0] o;
    exp_v = '{E_FETCH, E_DECODE, E_EXER, E_ALUWB, E_FETCH};
    bus.Op = 2'b00; bus.Funct = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      // Op/Funct wiggling in EXECUTER must not redirect the flow.
      if (i == 2) begin bus.Op = 2'b11; bus.Funct = 6'b111111; end
      o = obs();
      n_checks++;
      if (o !== exp_v[i]) $display("FAIL addr_c%0d got=%h exp=%h", i + 1, o, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_add_imm();
    logic [14:0] exp_v [5];
    logic [14:0] o;
    exp_v = '{E_FETCH, E_DECODE, E_EXEI, E_ALUWB, E_FETCH};
    bus.Op = 2'b00; bus.Funct = 6'b101000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      o = obs();
      n_checks++;
      if (o !== exp_v[i]) $display("FAIL addi_c%0d got=%h exp=%h", i + 1, o, exp_v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    logic [14:0] exp_v [4];
    logic [14:0] o;
    exp_v = '{E_FETCH, E_DECODE, E_BRANCH, E_FETCH};
    bus.Op = 2'b10; bus.Funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      o = obs();
      n_checks++;
      if (o !== exp_v[i]) $display("FAIL br_c%0d got=%h exp=%h", i + 1, o, exp_v[i]);
      else n_pass++;
    end
  endtask

  // Branch immediately followed by a load: no idle cycle between them.
  task automatic test_back_to_back();
    logic [14:0] exp_v [8];
    logic [14:0] o;
    exp_v = '{E_FETCH, E_DECODE, E_BRANCH, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
    bus.Op = 2'b10; bus.Funct = 6'b000001;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (i == 3) begin bus.Op = 2'b01; bus.Funct = 6'b000001; end
      o = obs();
      n_checks++;
      if (o !== exp_v[i]) $display("FAIL b2b_c%0d got=%h exp=%h", i + 1, o, exp_v[i]);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_illegal();
    logic [14:0] o;
    bus.Op = 2'b11; bus.Funct = 6'b000000;
    step();
    o = obs();
    n_checks++;
    if (o !== E_DECODE) $display("FAIL ill_decode got=%h exp=%h", o, E_DECODE);
    else n_pass++;
    step();
    o = obs();
    n_checks++;
    if (o !== E_UNK) $display("FAIL ill_entry got=%h exp=%h", o, E_UNK);
    else n_pass++;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      step();
      o = obs();
      n_checks++;
      if (o !== E_UNKH) $display("FAIL ill_hold[%0d] got=%h exp=%h", i, o, E_UNKH);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
`else
    step();
`endif
    o = obs();
    n_checks++;
    if (o !== E_FETCH) $display("FAIL ill_exit got=%h exp=%h", o, E_FETCH);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    logic [14:0] o;
    realtime t_edge;
    bus.Op = 2'b01; bus.Funct = 6'b000000;
    step(); step(); step();
    o = obs();
    n_checks++;
    if (o !== E_MEMWR) $display("FAIL abort_memwr got=%h exp=%h", o, E_MEMWR);
    else n_pass++;
    t_edge = $realtime;
    #2;
    reset = 1'b0;
    #1;
    o = obs();
    n_checks++;
    if (o !== E_RESET || ($realtime - t_edge) >= 10.0)
      $display("FAIL abort_async got=%h exp=%h", o, E_RESET);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    o = obs();
    n_checks++;
    if (o !== E_FETCH) $display("FAIL abort_release got=%h exp=%h", o, E_FETCH);
    else n_pass++;
  endtask

  initial begin
    bus.Op    = 2'b00;
    bus.Funct = 6'b000000;
    test_reset();
    test_ldr();
    test_str();
    test_add_reg();
    test_add_imm();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle control FSM in the ARM-subset processor's controller.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives the unconditioned strobes NextPC, RegW, MemW and Branch, plus datapath mux selects.
- Downstream condition logic gates the strobes with CondEx and flags; this block is the producer end of that interface.

Parameters:
- STATE_W, 4, width of the state register; must be at least 4 to encode all 11 states.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- Op  input  2  instruction op field, Instr[27:26].
- Funct  input  6  instruction funct field, Instr[25:20]. Funct[5] is the immediate bit; Funct[0] is the load/S bit.
- IRWrite  output  1  instruction register write enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
- ALUSrcA  output  2  ALU A select: 00 = reg A, 01 = PC, 10 = ALUOut.
- ALUSrcB  output  2  ALU B select: 00 = reg WD, 01 = ExtImm, 10 = constant 4.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = force ADD.
- NextPC  output  1  PC update request.
- RegW  output  1  register write request.
- MemW  output  1  memory write request.
- Branch  output  1  branch request.
- InstrDone  output  1  single-cycle pulse in the final state of each instruction.
- Illegal  output  1  undefined-op indicator; see Optional Feature.

Behaviour:
- Moore machine. All outputs decode from the state register only; no input-to-output combinational path.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- Transitions on the rising clk edge:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if Op=01; EXECUTER if Op=00 and Funct[5]=0; EXECUTEI if Op=00 and Funct[5]=1; BRANCH if Op=10; UNKNOWN if Op=11.
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH (default build).
- Outputs per state. Signals not listed are 0 or 00.
  - FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1, InstrDone=1.
  - MEMWR: AdrSrc=1, MemW=1, InstrDone=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1, InstrDone=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1, InstrDone=1.
  - UNKNOWN: all outputs 0, InstrDone=1.
- Latency: memory load 5 cycles; store 4; data-processing 4; branch 3.
- Reset:
  - reset=0 forces state to FETCH immediately, asynchronously.
  - While reset=0, IRWrite, NextPC, RegW, MemW, Branch and InstrDone are forced to 0.
  - Mux selects show FETCH values during reset.
  - First FETCH strobes appear in the cycle after reset deasserts.
  - Reset asserted mid-instruction (e.g. in MEMWR) aborts it; MemW drops the same instant.
- Unreachable state encodings recover to FETCH on the next edge with all strobes 0.
- Op and Funct are sampled only in DECODE and MEMADR; changes in other states have no effect.

Optional Feature:
- Macro MAIN_FSM_ILLEGAL_TRAP_EN.
- Defined: UNKNOWN is a sink state and holds until reset. Illegal=1 while in UNKNOWN, all strobes 0, InstrDone pulses once on entry only.
- Undefined: UNKNOWN lasts one cycle then returns to FETCH. Illegal is tied to 0.

Decomposition:
- Shared package main_fsm_pkg holds:
  - the state enum, width STATE_W;
  - encodings for ALUSrcA, ALUSrcB and ResultSrc;
  - Op encodings OP_DP=00, OP_MEM=01, OP_BR=10.
- One natural sub-module: main_fsm_outdec, a combinational state-to-output decode.
- The state register reuses the existing flopr with asynchronous active-low clear.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> state FETCH; all strobes 0 during reset; IRWrite=1 and NextPC=1 in first cycle after release.
- LDR: Op=01, Funct=011001 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegW=1 and ResultSrc=01 only in cycle 5; InstrDone pulses in cycle 5.
- STR: Op=01, Funct=011000 -> MemW=1, AdrSrc=1 in cycle 4 only; RegW never asserted; returns to FETCH in cycle 5.
- ADD reg vs immediate: Op=00, Funct=001000 -> EXECUTER (ALUSrcB=00); Funct=101000 -> EXECUTEI (ALUSrcB=01); both ALUWB with RegW=1 in cycle 4.
- Branch: Op=10 -> BRANCH in cycle 3 with Branch=1, ALUSrcA=10, ALUSrcB=01; FETCH in cycle 4.
- Illegal plus reset abort:
  - Op=11 -> UNKNOWN. Default build: FETCH next cycle. With MAIN_FSM_ILLEGAL_TRAP_EN: stays in UNKNOWN with Illegal=1 for 10 cycles.
  - Separately, assert reset mid-MEMWR -> MemW falls to 0 without a clock edge.
